// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: multi-cycle two's-complement adder/subtractor.
// Works through the operands SLICE bits per clock with a registered carry
// between slices, so only a SLICE-bit ripple sits in the critical path.
// WIDTH must be a multiple of SLICE; N = WIDTH/SLICE compute cycles.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (in_ready only while idle)
//   a, b, m              operands and mode (0: a+b, 1: a-b)
//   out_valid/out_ready  result handshake; outputs held while stalled
//   result               sum/difference mod 2^WIDTH
//   cout, ovf, zero, neg carry out of MSB (1 = no borrow in SUB),
//                        signed overflow, result==0, result MSB

// One slice of the ripple chain. Also exposes the carry into its top bit,
// which the final slice needs for signed overflow.
module seq_addsub_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             cmsb
);
  logic [SLICE:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < SLICE; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign co   = c[SLICE];
  assign cmsb = c[SLICE-1];
endmodule

module seq_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] opa, opb;   // opb already holds b ^ {WIDTH{m}}
  logic [WIDTH-1:0] acc;        // partial result, kept apart from the held output
  logic             carry;

  logic [WIDTH-1:0] sh_a, sh_b, acc_nxt;
  logic [SLICE-1:0] sa, sb, ss;
  logic             sco, scm, last;

  // Select the current slice by shifting rather than a variable part-select.
  always_comb begin
    sh_a    = opa >> (SLICE * int'(idx));
    sh_b    = opb >> (SLICE * int'(idx));
    sa      = sh_a[SLICE-1:0];
    sb      = sh_b[SLICE-1:0];
    // acc is cleared on accept, so OR-ing in the new slice is a plain write.
    acc_nxt = acc | (WIDTH'(ss) << (SLICE * int'(idx)));
    last    = (idx == IW'(N - 1));
  end

  seq_addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (sa),
    .b    (sb),
    .cin  (carry),
    .s    (ss),
    .co   (sco),
    .cmsb (scm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          opa   <= a;
          opb   <= b ^ {WIDTH{m}};
          carry <= m;               // +1 completes the two's complement of b
          idx   <= '0;
          acc   <= '0;
          state <= S_CALC;
        end
        S_CALC: begin
          acc   <= acc_nxt;
          carry <= sco;
          idx   <= idx + 1'b1;
          if (last) begin
            result <= acc_nxt;
            cout   <= sco;
            ovf    <= sco ^ scm;
            zero   <= (acc_nxt == '0);
            neg    <= acc_nxt[WIDTH-1];
            state  <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
endmodule

// File: tb/tb_seq_addsub_unit.sv
module tb_seq_addsub_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0, rst8_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // main instance: WIDTH=8, SLICE=2
  logic       iv8 = 0, ir8, ov8, or8 = 1, m8 = 0, c8, o8, z8, n8;
  logic [7:0] a8 = 0, b8 = 0, r8;
  // WIDTH=16, SLICE=4
  logic        iv16 = 0, ir16, ov16, m16 = 0, c16, o16, z16, n16;
  logic [15:0] a16 = 0, b16 = 0, r16;
  // WIDTH=4, SLICE=4
  logic       iv4 = 0, ir4, ov4, m4 = 0, c4, o4, z4, n4;
  logic [3:0] a4 = 0, b4 = 0, r4;

  logic [19:0] q8[$], q16[$], q4[$];
  logic [19:0] e8, e16, e4;

  seq_addsub_unit #(.WIDTH(8), .SLICE(2)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .m(m8), .out_valid(ov8), .out_ready(or8), .result(r8), .cout(c8), .ovf(o8),
    .zero(z8), .neg(n8));
  seq_addsub_unit #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .m(m16), .out_valid(ov16), .out_ready(1'b1), .result(r16), .cout(c16),
    .ovf(o16), .zero(z16), .neg(n16));
  seq_addsub_unit #(.WIDTH(4), .SLICE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .m(m4), .out_valid(ov4), .out_ready(1'b1), .result(r4), .cout(c4),
    .ovf(o4), .zero(z4), .neg(n4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic; returns {result[15:0], cout, ovf, zero, neg}.
  function automatic logic [19:0] model(input int w, input int a, input int b, input bit m);
    int mask, lm, bb, s, res, low;
    bit c, cm, z, n;
    mask = (1 << w) - 1;
    lm   = (1 << (w - 1)) - 1;
    bb   = (m ? ~b : b) & mask;
    s    = (a & mask) + bb + int'(m);
    res  = s & mask;
    c    = s[w];
    low  = (a & lm) + (bb & lm) + int'(m);
    cm   = low[w-1];
    z    = (res == 0);
    n    = res[w-1];
    return {res[15:0], c, c ^ cm, z, n};
  endfunction

  // Scoreboard monitors: pop on each completed output handshake.
  always @(negedge clk) if (rst8_n && ov8 && or8) begin
    if (q8.size() == 0) chk("sb8_extra", 1, 0);
    else begin e8 = q8.pop_front(); chk("res8", {12'h0, 8'h0, r8, c8, o8, z8, n8}, {12'h0, e8}); end
  end
  always @(negedge clk) if (rst_n && ov16) begin
    if (q16.size() == 0) chk("sb16_extra", 1, 0);
    else begin e16 = q16.pop_front(); chk("res16", {12'h0, r16, c16, o16, z16, n16}, {12'h0, e16}); end
  end
  always @(negedge clk) if (rst_n && ov4) begin
    if (q4.size() == 0) chk("sb4_extra", 1, 0);
    else begin e4 = q4.pop_front(); chk("res4", {12'h0, 12'h0, r4, c4, o4, z4, n4}, {12'h0, e4}); end
  end

  // One operation on the 8-bit unit with latency, busy and backpressure checks.
  task automatic do8(input logic [7:0] ta, input logic [7:0] tb, input logic tm, input int hold);
    int n, lat;
    logic [11:0] snap;
    @(posedge clk); #1;
    a8 = ta; b8 = tb; m8 = tm; iv8 = 1'b1; or8 = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!ir8 && n < 50) begin n++; @(negedge clk); end
    chk("acc_rdy", {31'h0, ir8}, 1);
    q8.push_back(model(8, int'(ta), int'(tb), tm));
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!ov8 && lat < 20) begin
      chk("calc_busy", {31'h0, ir8}, 0);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 4);
    if (hold > 0) begin
      snap = {r8, c8, o8, z8, n8};
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1; iv8 = 1'b1;
        @(negedge clk);
        chk("bp_stable", {20'h0, r8, c8, o8, z8, n8}, {20'h0, snap});
        chk("bp_valid", {30'h0, ov8, ir8}, 32'h2);
      end
      @(posedge clk); #1; iv8 = 1'b0; or8 = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("back_idle", {30'h0, ov8, ir8}, 32'h1);
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tm);
    int n;
    @(posedge clk); #1;
    a16 = ta; b16 = tb; m16 = tm; iv16 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir16 && n < 50) begin n++; @(negedge clk); end
    if (!ir16) chk("rdy16_timeout", 0, 1);
    else q16.push_back(model(16, int'(ta), int'(tb), tm));
    @(posedge clk); #1; iv16 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tm);
    int n;
    @(posedge clk); #1;
    a4 = ta; b4 = tb; m4 = tm; iv4 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir4 && n < 50) begin n++; @(negedge clk); end
    if (!ir4) chk("rdy4_timeout", 0, 1);
    else q4.push_back(model(4, int'(ta), int'(tb), tm));
    @(posedge clk); #1; iv4 = 1'b0;
  endtask

  initial begin
    int n;
    #3;
    chk("rst8_out", {19'h0, ov8, ir8, r8, c8, o8, z8, n8}, {19'h0, 1'b0, 1'b1, 12'h0});
    chk("rst16_out", {10'h0, ov16, ir16, r16, c16, o16, z16, n16}, {10'h0, 2'b01, 20'h0});
    @(posedge clk); #1; rst_n = 1'b1; rst8_n = 1'b1;

    fork
      begin
        do8(8'h05, 8'h03, 1'b0, 0);
        do8(8'h7F, 8'h01, 1'b0, 0);
        do8(8'hFF, 8'h01, 1'b0, 0);
        do8(8'h08, 8'h03, 1'b1, 0);
        do8(8'h04, 8'h05, 1'b1, 0);
        do8(8'h80, 8'h01, 1'b1, 0);
        do8(8'h5A, 8'h00, 1'b1, 0);
        do8(8'h3C, 8'h3C, 1'b1, 0);
        do8(8'hC3, 8'h5A, 1'b0, 3);
        // abort mid-CALC with reset
        @(posedge clk); #1; a8 = 8'h33; b8 = 8'h44; m8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        chk("abort_rdy", {31'h0, ir8}, 1);
        @(posedge clk); #1; iv8 = 1'b0;
        @(posedge clk); @(posedge clk);
        #2; rst8_n = 1'b0; #1;
        chk("abort_out", {19'h0, ov8, ir8, r8, c8, o8, z8, n8}, {19'h0, 1'b0, 1'b1, 12'h0});
        @(posedge clk); #1; rst8_n = 1'b1;
        repeat (6) begin
          @(negedge clk);
          chk("abort_quiet", {30'h0, ov8, ir8}, 32'h1);
        end
        do8(8'h10, 8'h20, 1'b0, 0);
        for (int i = 0; i < 6; i++)
          do8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
      begin
        op16(16'h0005, 16'h0003, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0);
        op16(16'h0008, 16'h0003, 1'b1);
        op16(16'h0004, 16'h0005, 1'b1);
        op16(16'h8000, 16'h0001, 1'b1);
        op16(16'hBEEF, 16'hBEEF, 1'b1);
        for (int i = 0; i < 4; i++) op16(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        op4(4'h5, 4'h3, 1'b0);
        op4(4'h7, 4'h1, 1'b0);
        op4(4'hF, 4'h1, 1'b0);
        op4(4'h8, 4'h3, 1'b1);
        op4(4'h4, 4'h5, 1'b1);
        op4(4'h8, 4'h1, 1'b1);
        op4(4'h9, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) op4(4'($urandom), 4'($urandom), 1'($urandom));
      end
    join

    n = 0;
    while ((q8.size() + q16.size() + q4.size()) != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", q8.size() + q16.size() + q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
